// File: rtl/student_iis_sched_pkg.sv
// Shared definitions for the IIS sample scheduler.
// Holds the scheduler state encoding, the per-sample processing mode
// encoding and the width of the dropped-sample counter.
package student_iis_sched_pkg;

    localparam int OVR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT_FIR = 2'd2,
        EMIT     = 2'd3
    } sched_state_e;

    typedef enum logic [1:0] {
        MODE_FIR    = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_MUTE   = 2'd2,
        MODE_HOLD   = 2'd3
    } sched_mode_e;

endpackage

// File: rtl/student_iis_sched_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i   - clock
//   clr_i   - synchronous clear to zero (has priority over inc_i)
//   inc_i   - add one when high, unless already at the maximum value
//   count_o - current count, sticks at all-ones once reached
module student_iis_sched_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    // Count up on request but never wrap: once all-ones, the value stays put
    // so software can tell that "at least this many" events happened.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/student_iis_sample_scheduler.sv
// IIS sample scheduler: takes one stereo pair per frame from the IIS
// receiver, pushes it through the FIR engine (or bypasses/mutes/holds it)
// and hands exactly one result pair to the IIS transmitter.
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   cfg_enable_i, cfg_mode_i  - accept enable, processing mode (see pkg)
//   rx_valid_i, rx_data_*_i   - receiver strobe and stereo sample
//   fir_start_o, fir_data_*_o - start pulse and latched sample to the FIR
//   fir_done_i, fir_data_*_i  - FIR completion strobe and result
//   tx_valid_o, tx_data_*_o   - transmitter strobe and output sample
//   busy_o                    - a sample is in flight
//   overrun_o, overrun_cnt_o  - dropped-sample pulse and saturating count
//   timeout_o                 - FIR did not answer in time
module student_iis_sample_scheduler
    import student_iis_sched_pkg::*;
#(
    parameter int DATA_SIZE         = 16,
    parameter int DATA_SIZE_FIR_OUT = 16,
    parameter int TIMEOUT_CYCLES    = 2048
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_enable_i,
    input  logic [1:0]                   cfg_mode_i,
    input  logic                         rx_valid_i,
    input  logic [DATA_SIZE-1:0]         rx_data_l_i,
    input  logic [DATA_SIZE-1:0]         rx_data_r_i,
    output logic                         fir_start_o,
    output logic [DATA_SIZE-1:0]         fir_data_l_o,
    output logic [DATA_SIZE-1:0]         fir_data_r_o,
    input  logic                         fir_done_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] fir_data_l_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] fir_data_r_i,
    output logic                         tx_valid_o,
    output logic [DATA_SIZE_FIR_OUT-1:0] tx_data_l_o,
    output logic [DATA_SIZE_FIR_OUT-1:0] tx_data_r_o,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic                         timeout_o,
    output logic [OVR_CNT_W-1:0]         overrun_cnt_o
);

    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    sched_state_e                 state_q;
    sched_state_e                 state_d;
    sched_mode_e                  rx_mode;
    logic                         accept;
    logic                         drop;
    logic                         done_take;
    logic                         to_hit;
    logic [TO_W-1:0]              to_cnt_q;
    logic [DATA_SIZE_FIR_OUT-1:0] bypass_l;
    logic [DATA_SIZE_FIR_OUT-1:0] bypass_r;

    assign rx_mode   = sched_mode_e'(cfg_mode_i);
    assign accept    = (state_q == IDLE) && rx_valid_i && cfg_enable_i;
    assign drop      = (state_q != IDLE) && rx_valid_i && cfg_enable_i;
    assign done_take = (state_q == WAIT_FIR) && fir_done_i;
    // A done arriving on the last allowed cycle still counts, so the
    // timeout only fires when done is absent on that edge.
    assign to_hit    = (state_q == WAIT_FIR) && !fir_done_i && (to_cnt_q == TO_LAST);

    // Bypass resizes the codec sample to the transmitter width: sign-extend
    // when growing, keep the MSBs when shrinking, plain copy when equal.
    generate
        if (DATA_SIZE_FIR_OUT > DATA_SIZE) begin : g_extend
            assign bypass_l = {{(DATA_SIZE_FIR_OUT-DATA_SIZE){rx_data_l_i[DATA_SIZE-1]}}, rx_data_l_i};
            assign bypass_r = {{(DATA_SIZE_FIR_OUT-DATA_SIZE){rx_data_r_i[DATA_SIZE-1]}}, rx_data_r_i};
        end else if (DATA_SIZE_FIR_OUT < DATA_SIZE) begin : g_truncate
            assign bypass_l = rx_data_l_i[DATA_SIZE-1 -: DATA_SIZE_FIR_OUT];
            assign bypass_r = rx_data_r_i[DATA_SIZE-1 -: DATA_SIZE_FIR_OUT];
        end else begin : g_equal
            assign bypass_l = rx_data_l_i;
            assign bypass_r = rx_data_r_i;
        end
    endgenerate

    // State register; reset aborts any in-flight sample on the spot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The mode is looked at only on acceptance, which is
    // what makes later mode changes harmless to the sample in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (rx_mode == MODE_FIR) ? DISPATCH : EMIT;
                end
            end
            DISPATCH: state_d = WAIT_FIR;
            WAIT_FIR: begin
                if (fir_done_i || (to_cnt_q == TO_LAST)) begin
                    state_d = EMIT;
                end
            end
            EMIT:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath: latch the accepted pair for the FIR, build the transmitter
    // sample (mode result or FIR result), run the FIR watchdog and register
    // the overrun/timeout pulses. FIR and hold modes leave tx data alone so a
    // timed-out FIR re-sends the previous sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fir_data_l_o <= '0;
            fir_data_r_o <= '0;
            tx_data_l_o  <= '0;
            tx_data_r_o  <= '0;
            to_cnt_q     <= '0;
            overrun_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            overrun_o <= drop;
            timeout_o <= to_hit;
            if (accept) begin
                fir_data_l_o <= rx_data_l_i;
                fir_data_r_o <= rx_data_r_i;
                case (rx_mode)
                    MODE_BYPASS: begin
                        tx_data_l_o <= bypass_l;
                        tx_data_r_o <= bypass_r;
                    end
                    MODE_MUTE: begin
                        tx_data_l_o <= '0;
                        tx_data_r_o <= '0;
                    end
                    default: begin
                    end
                endcase
            end
            if (state_q == DISPATCH) begin
                to_cnt_q <= '0;
            end else if (state_q == WAIT_FIR) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (done_take) begin
                tx_data_l_o <= fir_data_l_i;
                tx_data_r_o <= fir_data_r_i;
            end
        end
    end

    assign fir_start_o = (state_q == DISPATCH);
    assign tx_valid_o  = (state_q == EMIT);
    assign busy_o      = (state_q != IDLE);

    student_iis_sched_sat_counter #(
        .WIDTH (OVR_CNT_W)
    ) u_ovr_cnt (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .inc_i   (drop),
        .count_o (overrun_cnt_o)
    );

endmodule

// File: tb/tb_student_iis_sample_scheduler.sv
// Testbench for student_iis_sample_scheduler.
// A driver plans every transaction at the edge it is issued, pushing the
// expected fir_start / tx_valid / timeout / overrun events (with the edge at
// which each must appear) into per-kind queues; a monitor on the falling
// edge pops and compares whenever the DUT shows one of those events.
module tb_student_iis_sample_scheduler;

    localparam int DW = 16;
    localparam int OW = 24;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_enable_i = 1'b0;
    logic [1:0]    cfg_mode_i = 2'd0;
    logic          rx_valid_i = 1'b0;
    logic [DW-1:0] rx_data_l_i = '0;
    logic [DW-1:0] rx_data_r_i = '0;
    logic          fir_start_o;
    logic [DW-1:0] fir_data_l_o;
    logic [DW-1:0] fir_data_r_o;
    logic          fir_done_i = 1'b0;
    logic [OW-1:0] fir_data_l_i = '0;
    logic [OW-1:0] fir_data_r_i = '0;
    logic          tx_valid_o;
    logic [OW-1:0] tx_data_l_o;
    logic [OW-1:0] tx_data_r_o;
    logic          busy_o;
    logic          overrun_o;
    logic          timeout_o;
    logic [15:0]   overrun_cnt_o;

    student_iis_sample_scheduler #(
        .DATA_SIZE         (DW),
        .DATA_SIZE_FIR_OUT (OW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cfg_enable_i  (cfg_enable_i),
        .cfg_mode_i    (cfg_mode_i),
        .rx_valid_i    (rx_valid_i),
        .rx_data_l_i   (rx_data_l_i),
        .rx_data_r_i   (rx_data_r_i),
        .fir_start_o   (fir_start_o),
        .fir_data_l_o  (fir_data_l_o),
        .fir_data_r_o  (fir_data_r_o),
        .fir_done_i    (fir_done_i),
        .fir_data_l_i  (fir_data_l_i),
        .fir_data_r_i  (fir_data_r_i),
        .tx_valid_o    (tx_valid_o),
        .tx_data_l_o   (tx_data_l_o),
        .tx_data_r_o   (tx_data_r_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .timeout_o     (timeout_o),
        .overrun_cnt_o (overrun_cnt_o)
    );

    always #5 clk = ~clk;

    // Edge numbering: after the n-th rising edge edge_cnt == n.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            edge_n;
        logic [OW-1:0] l;
        logic [OW-1:0] r;
    } ev_t;

    // Event kinds: 0 fir_start, 1 tx_valid, 2 timeout, 3 overrun.
    ev_t   evq [4][$];
    string kname [4] = '{"fir_start", "tx_valid", "timeout", "overrun"};
    bit    busy_map [0:131071];

    // Reference model state, one transaction at a time.
    int            busy_until = 0;
    int            done_edge  = -1;
    logic [OW-1:0] done_l = '0;
    logic [OW-1:0] done_r = '0;
    int            wait_lo = 1;
    int            wait_hi = 0;
    logic [OW-1:0] last_l = '0;
    logic [OW-1:0] last_r = '0;
    int            ovr_model = 0;

    function automatic logic [OW-1:0] widen(input logic [DW-1:0] s);
        int v;
        v = int'($signed(s));
        return OW'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushEv(input int k, input int e, input logic [OW-1:0] l, input logic [OW-1:0] r);
        ev_t ev;
        ev.edge_n = e;
        ev.l      = l;
        ev.r      = r;
        evq[k].push_back(ev);
    endtask

    task automatic checkResetState();
        checkOutput("rst fir_start", 32'(fir_start_o), 32'd0);
        checkOutput("rst fir_data_l", 32'(fir_data_l_o), 32'd0);
        checkOutput("rst fir_data_r", 32'(fir_data_r_o), 32'd0);
        checkOutput("rst tx_valid", 32'(tx_valid_o), 32'd0);
        checkOutput("rst tx_data_l", 32'(tx_data_l_o), 32'd0);
        checkOutput("rst tx_data_r", 32'(tx_data_r_o), 32'd0);
        checkOutput("rst busy", 32'(busy_o), 32'd0);
        checkOutput("rst overrun", 32'(overrun_o), 32'd0);
        checkOutput("rst timeout", 32'(timeout_o), 32'd0);
        checkOutput("rst overrun_cnt", 32'(overrun_cnt_o), 32'd0);
    endtask

    // Model of one accepted sample: decides when fir_start and tx_valid
    // appear and what data they carry.
    task automatic acceptSample(input int e, input logic [1:0] mode, input logic [DW-1:0] l,
                                input logic [DW-1:0] r, input int dd,
                                input logic [OW-1:0] dl, input logic [OW-1:0] dr);
        int tx_edge;
        tx_edge = e;
        wait_lo = 1;
        wait_hi = 0;
        done_edge = -1;
        case (mode)
            2'd0: begin
                pushEv(0, e, OW'(l), OW'(r));
                wait_lo = e + 2;
                if (dd >= 0 && dd <= TO - 1) begin
                    tx_edge   = e + 2 + dd;
                    done_edge = tx_edge;
                    done_l    = dl;
                    done_r    = dr;
                    last_l    = dl;
                    last_r    = dr;
                end else begin
                    tx_edge = e + TO + 1;
                    pushEv(2, tx_edge, '0, '0);
                    if (dd >= 0) begin
                        done_edge = e + 2 + dd;
                        done_l    = dl;
                        done_r    = dr;
                    end
                end
                wait_hi = tx_edge;
            end
            2'd1: begin
                last_l = widen(l);
                last_r = widen(r);
            end
            2'd2: begin
                last_l = '0;
                last_r = '0;
            end
            default: begin
            end
        endcase
        pushEv(1, tx_edge, last_l, last_r);
        for (int j = e; j <= tx_edge; j++) busy_map[j] = 1'b1;
        busy_until = tx_edge + 1;
    endtask

    // Drive the inputs for the next rising edge, update the model, then
    // return 2 time units after that edge.
    task automatic applyStimulus(input bit rst, input bit rv, input bit en, input logic [1:0] mode,
                                 input logic [DW-1:0] l, input logic [DW-1:0] r, input int dd,
                                 input logic [OW-1:0] dl, input logic [OW-1:0] dr, input bit stray);
        int e;
        e = edge_cnt + 1;
        rst_i        = rst;
        rx_valid_i   = rv;
        cfg_enable_i = en;
        cfg_mode_i   = mode;
        rx_data_l_i  = l;
        rx_data_r_i  = r;
        fir_done_i   = 1'b0;
        fir_data_l_i = OW'($urandom);
        fir_data_r_i = OW'($urandom);
        if (done_edge == e) begin
            fir_done_i   = 1'b1;
            fir_data_l_i = done_l;
            fir_data_r_i = done_r;
        end else if (stray && !(e >= wait_lo && e <= wait_hi)) begin
            fir_done_i = 1'b1;
        end
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                while (evq[k].size() > 0 && evq[k][$].edge_n >= e) void'(evq[k].pop_back());
            end
            for (int j = e; j < e + TO + 8; j++) busy_map[j] = 1'b0;
            last_l     = '0;
            last_r     = '0;
            ovr_model  = 0;
            done_edge  = -1;
            wait_lo    = 1;
            wait_hi    = 0;
            busy_until = e;
        end else if (rv && en) begin
            if (e > busy_until) begin
                acceptSample(e, mode, l, r, dd, dl, dr);
            end else begin
                if (ovr_model < 65535) ovr_model++;
                pushEv(3, e, OW'(ovr_model), '0);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0, '0, -1, '0, '0, 1'b0);
    endtask

    // Monitor: every DUT event must match the oldest expected one of its
    // kind at the right edge; an expected event whose edge has passed
    // unseen is reported as missing.
    always @(negedge clk) begin
        int            n;
        ev_t           ev;
        logic          seen;
        logic [OW-1:0] al;
        logic [OW-1:0] ar;
        n = edge_cnt;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin seen = fir_start_o; al = OW'(fir_data_l_o); ar = OW'(fir_data_r_o); end
                1: begin seen = tx_valid_o;  al = tx_data_l_o;       ar = tx_data_r_o;       end
                2: begin seen = timeout_o;   al = '0;                ar = '0;                end
                default: begin seen = overrun_o; al = OW'(overrun_cnt_o); ar = '0; end
            endcase
            if (seen) begin
                if (evq[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL %s unexpected at edge %0d: got pulse expected none", kname[k], n);
                end else begin
                    ev = evq[k].pop_front();
                    checkOutput({kname[k], " edge"}, 32'(n), 32'(ev.edge_n));
                    if (k < 2) begin
                        checkOutput({kname[k], " left"}, 32'(al), 32'(ev.l));
                        checkOutput({kname[k], " right"}, 32'(ar), 32'(ev.r));
                    end else if (k == 3) begin
                        checkOutput({kname[k], " count"}, 32'(al), 32'(ev.l));
                    end
                end
            end else if (evq[k].size() > 0 && evq[k][0].edge_n <= n) begin
                ev = evq[k].pop_front();
                checks++;
                failures++;
                $display("[TB] FAIL %s missing: got no pulse by edge %0d expected at edge %0d", kname[k], n, ev.edge_n);
            end
        end
        checkOutput("busy", 32'(busy_o), 32'(busy_map[n]));
    end

    initial begin
        int guard;
        @(posedge clk);
        #2;
        checkResetState();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, '0, -1, '0, '0, 1'b0);
        idle(2);

        // FIR path: done five edges after acceptance.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'h1234, 16'hABCD, 3, 24'h000F0F, 24'h00F0F0, 1'b0);
        idle(TO + 4);

        // Bypass with sign extension to the wider transmitter width.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 16'h8001, 16'h7FFE, -1, '0, '0, 1'b0);
        idle(3);

        // Mute, then hold keeps the muted zero.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 16'h5555, 16'hAAAA, -1, '0, '0, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 16'h1111, 16'h2222, -1, '0, '0, 1'b0);
        idle(3);

        // Timeout re-emits the previous bypass sample; the late done lands in IDLE.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 16'h1357, 16'hF00D, -1, '0, '0, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'h0A0A, 16'h0B0B, TO + 1, 24'hDEAD01, 24'hBEEF02, 1'b0);
        idle(TO + 6);

        // Done on the very edge the watchdog would fire: done wins.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'h4242, 16'h2424, TO - 1, 24'h123456, 24'h654321, 1'b0);
        idle(TO + 4);

        // Drops during an in-flight FIR sample, some with enable low (ignored).
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'h7777, 16'h8888, 5, 24'hA5A5A5, 24'h5A5A5A, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, (i % 3) != 0, 2'd3, 16'(i), 16'(i + 1), -1, '0, '0, 1'b0);
        end
        idle(TO + 4);

        // Reset in the middle of WAIT_FIR: nothing may come out for that sample.
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'h9999, 16'h6666, -1, '0, '0, 1'b0);
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0, '0, -1, '0, '0, 1'b0);
        checkResetState();
        idle(TO + 4);

        // Randomized traffic with mode changes, drops and stray done strobes.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'b0, ($urandom % 4) == 0, ($urandom % 4) != 0, 2'($urandom),
                          DW'($urandom), DW'($urandom), int'($urandom_range(0, TO + 1)),
                          OW'($urandom), OW'($urandom), ($urandom % 8) == 0);
        end
        idle(TO + 6);

        // Saturate the dropped-sample counter with back-to-back receiver strobes.
        guard = 0;
        while (ovr_model < 65535 && guard < 80000) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, DW'($urandom), DW'($urandom), -1, '0, '0, 1'b0);
            guard++;
        end
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, DW'($urandom), DW'($urandom), -1, '0, '0, 1'b0);
        end
        idle(TO + 6);

        checkOutput("overrun_cnt saturated", 32'(overrun_cnt_o), 32'h0000FFFF);
        for (int k = 0; k < 4; k++) begin
            checkOutput({kname[k], " queue drained"}, 32'(evq[k].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/student_iis_sample_scheduler.md
Name: student_iis_sample_scheduler

Overview:
Sequences one stereo sample per IIS frame from the IIS receiver through the parallel FIR engine and back to the IIS transmitter. Accepts a receiver strobe, dispatches the pair with a start pulse, and waits for FIR completion with a timeout. It then emits a single-cycle valid strobe and data to the transmitter. Also provides bypass, mute and hold modes, plus overrun/timeout reporting for the register file.

Parameters:
DATA_SIZE, 16, width of receiver/codec-side samples
DATA_SIZE_FIR_OUT, 16, width of FIR output / transmitter samples
TIMEOUT_CYCLES, 2048, max clk_i cycles spent waiting for fir_done_i (>=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
cfg_enable_i  in  1  1 = accept new samples
cfg_mode_i  in  2  0 FIR, 1 bypass, 2 mute, 3 hold-last
rx_valid_i  in  1  one-cycle strobe from IIS receiver
rx_data_l_i  in  DATA_SIZE  left sample
rx_data_r_i  in  DATA_SIZE  right sample
fir_start_o  out  1  one-cycle start pulse to FIR
fir_data_l_o  out  DATA_SIZE  latched left sample to FIR
fir_data_r_o  out  DATA_SIZE  latched right sample to FIR
fir_done_i  in  1  one-cycle FIR completion strobe
fir_data_l_i  in  DATA_SIZE_FIR_OUT  FIR left result, valid with fir_done_i
fir_data_r_i  in  DATA_SIZE_FIR_OUT  FIR right result, valid with fir_done_i
tx_valid_o  out  1  one-cycle strobe to IIS transmitter
tx_data_l_o  out  DATA_SIZE_FIR_OUT  left output sample
tx_data_r_o  out  DATA_SIZE_FIR_OUT  right output sample
busy_o  out  1  state != IDLE
overrun_o  out  1  one-cycle pulse: sample dropped
timeout_o  out  1  one-cycle pulse: FIR timeout
overrun_cnt_o  out  16  saturating dropped-sample count

Behaviour:
- Reset (rst_i high at a clk_i edge): state IDLE; every output 0, including tx/fir data registers, overrun_cnt_o and the timeout counter.
- FSM states IDLE, DISPATCH, WAIT_FIR, EMIT. All outputs are registered or decoded from state.
- IDLE, with rx_valid_i & cfg_enable_i at edge k:
  - Latch rx data into fir_data_*_o.
  - Snapshot cfg_mode_i. Mode changes after acceptance do not affect the in-flight sample.
  - Mode FIR: go to DISPATCH.
  - Any other mode: compute the output and go to EMIT.
  - rx_valid_i with cfg_enable_i=0 is ignored silently; it is not an overrun.
- DISPATCH (cycle k+1): fir_start_o=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_FIR.
- WAIT_FIR:
  - Counter increments every cycle.
  - fir_done_i at edge m: latch fir_data_*_i into tx_data_*_o, go to EMIT (tx_valid_o high during cycle m+1).
  - Counter == TIMEOUT_CYCLES-1 without done: timeout_o pulse on the next cycle, tx_data unchanged (previous sample re-emitted), go to EMIT.
  - done and timeout on the same edge: done wins, no timeout pulse.
- EMIT: tx_valid_o=1 for exactly one cycle, then IDLE.
- Latency: bypass/mute/hold gives tx_valid_o at cycle k+1. FIR gives fir_start_o at k+1 and tx_valid_o one cycle after fir_done_i.
- Width rule for bypass (DATA_SIZE to DATA_SIZE_FIR_OUT):
  - Wider output: sign-extend.
  - Narrower output: keep the MSBs and drop the LSBs (no rounding).
  - Equal widths: pass through.
- Mute: tx_data = 0. Hold: tx_data unchanged, tx_valid_o still pulses.
- Overrun:
  - rx_valid_i & cfg_enable_i while state != IDLE drops the sample.
  - overrun_o pulses on the next cycle.
  - overrun_cnt_o increments and saturates at 0xFFFF.
  - The in-flight operation is unaffected.
- fir_done_i outside WAIT_FIR is ignored.
- cfg_enable_i deasserted mid-operation: the current sample completes normally; no new acceptance.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; no tx_valid_o or fir_start_o is produced for the aborted sample.

Decomposition:
- Shared package student_iis_sched_pkg holds:
  - state enum sched_state_e (IDLE, DISPATCH, WAIT_FIR, EMIT)
  - mode enum sched_mode_e (MODE_FIR=0, MODE_BYPASS=1, MODE_MUTE=2, MODE_HOLD=3)
  - OVR_CNT_W=16
- One sub-module, student_iis_sched_sat_counter (parameterised width, sync clear, increment, saturate), used for overrun_cnt_o.
- The timeout counter is inline.

Test Plan:
- FIR path: mode 0, rx L=0x1234 R=0xABCD at edge k, fir_done_i with 0x0F0F/0xF0F0 five cycles later -> fir_start_o at k+1 with data 0x1234/0xABCD; tx_valid_o one cycle after done with 0x0F0F/0xF0F0; busy_o high throughout.
- Bypass width: DATA_SIZE=16, DATA_SIZE_FIR_OUT=24, rx L=0x8001 -> tx_valid_o at k+1, tx_data_l_o=0xFF8001, fir_start_o never asserted.
- Mute then hold: mode 2 sample -> tx=0. Mode 3 sample -> tx=0 again with tx_valid_o pulse.
- Timeout: TIMEOUT_CYCLES=8, no fir_done_i -> timeout_o one pulse; tx_valid_o re-emits the previous sample; later fir_done_i in IDLE is ignored.
- Overrun: second rx_valid_i during WAIT_FIR, repeated 70000 times -> overrun_o pulse per drop; overrun_cnt_o saturates at 0xFFFF; the first sample still completes.
- Reset mid-WAIT_FIR and done/timeout on the same edge:
  - rst_i in WAIT_FIR -> all outputs 0, no tx_valid_o.
  - Separately, done on the TIMEOUT edge -> no timeout_o, FIR data emitted.
